counter_seq_monitor: RTL
========================

# counter_seq_monitor

Downstream checker for the free-running 4-bit up counter. It samples the counter output every enabled clock and verifies that each value is the previous value plus one, modulo 2^DATA_SIZE. It reports wrap events (all-ones to zero) and sequence errors as single-cycle pulses, and keeps saturating statistics counters. It sits directly on the counter's q_out bus and feeds the status/debug logic.

## Interface
- DATA_SIZE, 4, width of the monitored count bus
- SYNC_LEN, 2, consecutive correct increments required to declare lock (≥1)
- STAT_W, 8, width of wrap_count and err_count
- clk  input  1  single system clock, rising-edge
- reset_n  input  1  asynchronous, active-low reset
- count_in  input  DATA_SIZE  counter value being monitored
- count_valid  input  1  count_in is sampled on this edge; low = ignore the cycle
- clr  input  1  synchronous clear of the statistics (wrap_count, err_count, err_sticky)
- locked  output  1  high while the FSM is in TRACK
- wrap_pulse  output  1  one-cycle pulse per detected wrap while locked
- err_pulse  output  1  one-cycle pulse per sequence error while locked
- err_sticky  output  1  set by any error; cleared only by clr or reset
- wrap_count  output  STAT_W  number of wraps seen, saturating at all-ones
- err_count  output  STAT_W  number of errors seen, saturating at all-ones
- state_out  output  2  FSM state: IDLE=00, SYNC=01, TRACK=10, ERROR=11

## Operation
- Internal registers: prev (DATA_SIZE), match_cnt (holds 0..SYNC_LEN).
- "Match" means count_in == prev + 1, truncated to DATA_SIZE bits. This definition covers 15 -> 0 when DATA_SIZE = 4.
- A cycle with count_valid = 0 is a no-op:
  - state, prev, match_cnt and the statistics hold.
  - Both pulses are 0.
- IDLE:
  - On the first valid sample: prev <= count_in, match_cnt <= 0, go to SYNC.
- SYNC:
  - On a valid sample: prev <= count_in.
  - Match: match_cnt increments. When the incremented value equals SYNC_LEN, go to TRACK.
  - Mismatch: match_cnt <= 0, stay in SYNC.
  - No pulses and no statistics updates occur in SYNC.
- TRACK:
  - On a valid sample: prev <= count_in.
  - Match with prev = all-ones (so count_in = 0): wrap_pulse = 1 and wrap_count increments.
  - Mismatch: err_pulse = 1, err_count increments, err_sticky <= 1, go to ERROR.
- ERROR:
  - Lasts exactly one cycle regardless of count_valid, then goes to SYNC with match_cnt = 0.
  - If count_valid = 1 in this cycle, prev <= count_in. No other update occurs.
- Statistics saturate: an increment at all-ones holds the value at all-ones.
- clr priority:
  - clr = 1 zeroes wrap_count, err_count and err_sticky, overriding a same-cycle increment or set.
  - wrap_pulse and err_pulse are still emitted for a same-cycle event.
  - The FSM, prev and match_cnt are unaffected by clr.
- Reset (asynchronous assert):
  - State goes to IDLE; prev and match_cnt go to 0.
  - Every output goes to 0: locked, wrap_pulse, err_pulse, err_sticky, wrap_count, err_count and state_out (00).
  - Deassertion is synchronous to clk. The first valid sample after deassertion is treated as in IDLE.

## Timing
- All outputs are registered. The response to a sample taken at edge k is visible after edge k and stays valid until edge k+1.
- wrap_pulse and err_pulse are high for exactly one clock per event. They are never both high.
- Lock latency with continuous valid correct counting: first sample at edge 0 (IDLE -> SYNC), then SYNC_LEN further samples. locked rises after edge SYNC_LEN (edge 2 by default).
- Recovery after an error: ERROR lasts 1 cycle, then SYNC needs SYNC_LEN matches. The sample taken during ERROR becomes the SYNC reference.
- Gaps in count_valid do not break lock. The comparison is always against the last valid sample.
- A reset asserted mid-TRACK drops locked immediately, without waiting for a clock edge.

## Test plan
- Reset, then count_valid = 1 with count_in = 0,1,2,3,… -> locked = 1 after the 3rd sampled edge; state_out = 10; err_count = 0.
- Locked, drive 13,14,15,0,1 -> one wrap_pulse on the cycle after 0 is sampled; wrap_count = 1.
- Locked at 5, drive 7 -> err_pulse for one cycle; err_sticky = 1; err_count = 1; state_out goes 11 then 01; with 8,9,10 following, locked returns after the 10 is sampled.
- Locked, count_valid low for 3 cycles while count_in is garbage, then resume with the previous value + 1 -> no error, locked stays 1.
- STAT_W = 2, force 5 errors -> err_count stays 3; clr in the same cycle as an error -> err_pulse = 1, err_count = 0, err_sticky = 0.
- Assert reset_n low mid-TRACK between clock edges -> all outputs 0 immediately; after release, relock in SYNC_LEN + 1 valid samples.

Source files
------------

// File: rtl/counter_seq_monitor.sv
// Sequence checker for a free-running up counter: tracks lock on a +1 sequence,
// flags wraps and sequence breaks, and keeps saturating statistics.
module counter_seq_monitor #(
  parameter int DATA_SIZE = 4,
  parameter int SYNC_LEN  = 2,
  parameter int STAT_W    = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DATA_SIZE-1:0] count_in,
  input  logic                 count_valid,
  input  logic                 clr,
  output logic                 locked,
  output logic                 wrap_pulse,
  output logic                 err_pulse,
  output logic                 err_sticky,
  output logic [STAT_W-1:0]    wrap_count,
  output logic [STAT_W-1:0]    err_count,
  output logic [1:0]           state_out
);

  localparam int CNT_W = $clog2(SYNC_LEN + 1);
  localparam logic [CNT_W-1:0] SYNC_LEN_C = CNT_W'(SYNC_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SYNC  = 2'b01,
    TRACK = 2'b10,
    ERROR = 2'b11
  } state_e;

  state_e               state_q, state_d;
  logic [DATA_SIZE-1:0] prev_q, prev_d;
  logic [CNT_W-1:0]     match_cnt_q, match_cnt_d;

  logic                 wrap_pulse_q, wrap_pulse_d;
  logic                 err_pulse_q, err_pulse_d;
  logic                 err_sticky_q, err_sticky_d;
  logic                 locked_q, locked_d;
  logic [STAT_W-1:0]    wrap_count_q, wrap_count_d;
  logic [STAT_W-1:0]    err_count_q, err_count_d;

  logic [DATA_SIZE-1:0] prevInc;
  logic [CNT_W-1:0]     matchInc;
  logic                 isMatch;
  logic                 wrapEvent;
  logic                 errEvent;

  // Held in a DATA_SIZE-wide net so all-ones + 1 wraps to zero before comparing.
  assign prevInc   = prev_q + 1'b1;
  assign matchInc  = match_cnt_q + 1'b1;
  assign isMatch   = (count_in == prevInc);
  assign wrapEvent = (state_q == TRACK) && count_valid && isMatch && (prev_q == '1);
  assign errEvent  = (state_q == TRACK) && count_valid && !isMatch;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      prev_q      <= '0;
      match_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    match_cnt_d = match_cnt_q;
    case (state_q)
      IDLE: begin
        if (count_valid) begin
          prev_d      = count_in;
          match_cnt_d = '0;
          state_d     = SYNC;
        end
      end
      SYNC: begin
        if (count_valid) begin
          prev_d = count_in;
          if (isMatch) begin
            match_cnt_d = matchInc;
            if (matchInc == SYNC_LEN_C) state_d = TRACK;
          end else begin
            match_cnt_d = '0;
          end
        end
      end
      TRACK: begin
        if (count_valid) begin
          prev_d = count_in;
          if (!isMatch) state_d = ERROR;
        end
      end
      ERROR: begin
        // The sample seen here, if any, becomes the new SYNC reference.
        if (count_valid) prev_d = count_in;
        match_cnt_d = '0;
        state_d     = SYNC;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wrap_pulse_d = wrapEvent;
    err_pulse_d  = errEvent;
    locked_d     = (state_d == TRACK);
    wrap_count_d = wrap_count_q;
    err_count_d  = err_count_q;
    err_sticky_d = err_sticky_q;
    if (clr) begin
      wrap_count_d = '0;
      err_count_d  = '0;
      err_sticky_d = 1'b0;
    end else begin
      if (wrapEvent && (wrap_count_q != '1)) wrap_count_d = wrap_count_q + 1'b1;
      if (errEvent && (err_count_q != '1))   err_count_d  = err_count_q + 1'b1;
      if (errEvent)                          err_sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrap_pulse_q <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      locked_q     <= 1'b0;
      wrap_count_q <= '0;
      err_count_q  <= '0;
    end else begin
      wrap_pulse_q <= wrap_pulse_d;
      err_pulse_q  <= err_pulse_d;
      err_sticky_q <= err_sticky_d;
      locked_q     <= locked_d;
      wrap_count_q <= wrap_count_d;
      err_count_q  <= err_count_d;
    end
  end

  assign locked     = locked_q;
  assign wrap_pulse = wrap_pulse_q;
  assign err_pulse  = err_pulse_q;
  assign err_sticky = err_sticky_q;
  assign wrap_count = wrap_count_q;
  assign err_count  = err_count_q;
  assign state_out  = state_q;

endmodule
